// File: rtl/led_recv.sv
// -----------------------------------------------------------------------------
// led_recv -- receiver for an APA102-style serial LED stream.
//
// A packet is a start frame of at least 32 zero bits, LED_NUM LED frames of
// 32 bits each (3'b111, 5-bit brightness, 24-bit BGR, MSB first), and a
// 32-bit all-ones end frame. Every LED frame is written to a downstream FIFO.
// Protocol violations and optional timeouts produce a one-clk err pulse.
//
// Parameters:
//   LED_NUM      LED frames expected between start and end frame
//   TIMEOUT_CNT  clk cycles without a cki edge, mid-packet, before abort
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   cki        in   serial LED clock (asynchronous, at most clk/4)
//   sdi        in   serial LED data, sampled on cki rising edge
//   fifo_full  in   downstream FIFO cannot accept a write
//   wr         out  one-clk FIFO write strobe
//   wr_data    out  frame bits [23:0], valid while wr is high
//   wr_bright  out  frame bits [28:24], valid while wr is high
//   frame_done out  one-clk pulse when a valid end frame completes
//   err        out  one-clk pulse on a protocol error or timeout
//   ovf        out  sticky: an LED frame was dropped because of fifo_full
//   busy       out  receiver is inside a packet (state is not HUNT)
//   led_cnt    out  LED frames received in the current packet
//
// Configuration macro:
//   LED_RECV_TIMEOUT_EN  when defined, a stalled packet is aborted after
//                        TIMEOUT_CNT clk cycles; otherwise it waits forever.
//
// Latency: wr / frame_done appear 4 clk cycles after the final cki rising
// edge at the pin (2 synchronizer stages, 1 bit-capture stage, 1 output reg).
// -----------------------------------------------------------------------------
module led_recv #(
  parameter int LED_NUM     = 4,
  parameter int TIMEOUT_CNT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cki,
  input  logic        sdi,
  input  logic        fifo_full,
  output logic        wr,
  output logic [23:0] wr_data,
  output logic [4:0]  wr_bright,
  output logic        frame_done,
  output logic        err,
  output logic        ovf,
  output logic        busy,
  output logic [10:0] led_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_FRAME = 2'd1,
    ST_END   = 2'd2
  } state_t;

  localparam logic [10:0] LED_NUM_C = 11'(LED_NUM);

  state_t      state_r;
  state_t      state_nxt_s;

  logic        cki_s1_r;
  logic        cki_s2_r;
  logic        cki_s3_r;
  logic        sdi_s1_r;
  logic        sdi_s2_r;
  logic        rise_s;

  logic        bit_vld_r;
  logic        bit_r;

  logic [5:0]  zero_cnt_r;
  logic [4:0]  bit_cnt_r;
  logic [30:0] shift_r;

  logic [31:0] word_s;
  logic        last_s;
  logic        frame_ok_s;
  logic        hunt_start_s;
  logic [10:0] led_cnt_inc_s;
  logic        tmo_hit_s;

  logic        wr_nxt_s;
  logic        done_nxt_s;
  logic        err_nxt_s;
  logic        drop_s;
  logic        led_inc_s;

  // The full frame as it stands once the current bit is shifted in.
  assign word_s        = {shift_r, bit_r};
  assign last_s        = bit_vld_r && (bit_cnt_r == 5'd31);
  assign frame_ok_s    = (word_s[31:29] == 3'b111);
  assign hunt_start_s  = (state_r == ST_HUNT) && bit_vld_r && bit_r && (zero_cnt_r == 6'd32);
  assign led_cnt_inc_s = led_cnt + 11'd1;
  assign rise_s        = cki_s2_r && !cki_s3_r;

`ifdef LED_RECV_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CNT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CNT - 1);

  logic [TMO_W-1:0] tmo_cnt_r;

  // Counts clk cycles since the last received bit while inside a packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (bit_vld_r || (state_nxt_s == ST_HUNT)) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  assign tmo_hit_s = (state_r != ST_HUNT) && !bit_vld_r && (tmo_cnt_r == TMO_LAST);
`else
  // Timeout disabled: the expression is constant 0 for any legal TIMEOUT_CNT.
  assign tmo_hit_s = (TIMEOUT_CNT < 0);
`endif

  // Two-stage synchronizers for cki and sdi, plus a delayed cki for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      cki_s1_r <= 1'b0;
      cki_s2_r <= 1'b0;
      cki_s3_r <= 1'b0;
      sdi_s1_r <= 1'b0;
      sdi_s2_r <= 1'b0;
    end else begin
      cki_s1_r <= cki;
      cki_s2_r <= cki_s1_r;
      cki_s3_r <= cki_s2_r;
      sdi_s1_r <= sdi;
      sdi_s2_r <= sdi_s1_r;
    end
  end

  // Captures the data bit in the cycle a cki rising edge is detected.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_vld_r <= 1'b0;
      bit_r     <= 1'b0;
    end else begin
      bit_vld_r <= rise_s;
      bit_r     <= rise_s ? sdi_s2_r : bit_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (hunt_start_s) begin
          state_nxt_s = ST_FRAME;
        end else begin
          state_nxt_s = ST_HUNT;
        end
      end
      ST_FRAME: begin
        if (tmo_hit_s) begin
          state_nxt_s = ST_HUNT;
        end else if (last_s) begin
          if (!frame_ok_s) begin
            state_nxt_s = ST_HUNT;
          end else if (led_cnt_inc_s == LED_NUM_C) begin
            state_nxt_s = ST_END;
          end else begin
            state_nxt_s = ST_FRAME;
          end
        end else begin
          state_nxt_s = ST_FRAME;
        end
      end
      ST_END: begin
        if (tmo_hit_s || last_s) begin
          state_nxt_s = ST_HUNT;
        end else begin
          state_nxt_s = ST_END;
        end
      end
      default: begin
        state_nxt_s = ST_HUNT;
      end
    endcase
  end

  // FSM output decode: at most one of wr / frame_done / err per cycle.
  always_comb begin
    wr_nxt_s   = 1'b0;
    done_nxt_s = 1'b0;
    err_nxt_s  = 1'b0;
    drop_s     = 1'b0;
    led_inc_s  = 1'b0;
    case (state_r)
      ST_FRAME: begin
        if (tmo_hit_s) begin
          err_nxt_s = 1'b1;
        end else if (last_s) begin
          if (!frame_ok_s) begin
            err_nxt_s = 1'b1;
          end else begin
            led_inc_s = 1'b1;
            if (fifo_full) begin
              drop_s = 1'b1;
            end else begin
              wr_nxt_s = 1'b1;
            end
          end
        end else begin
          err_nxt_s = 1'b0;
        end
      end
      ST_END: begin
        // All-ones here is always the end frame, never a white LED frame.
        if (tmo_hit_s) begin
          err_nxt_s = 1'b1;
        end else if (last_s) begin
          if (word_s == 32'hFFFF_FFFF) begin
            done_nxt_s = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          err_nxt_s = 1'b0;
        end
      end
      default: begin
        err_nxt_s = 1'b0;
      end
    endcase
  end

  // Start-frame zero counter, saturating at 32; cleared when a packet ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt_r <= 6'd0;
    end else if (state_r == ST_HUNT) begin
      if (bit_vld_r) begin
        if (bit_r) begin
          zero_cnt_r <= 6'd0;
        end else if (zero_cnt_r != 6'd32) begin
          zero_cnt_r <= zero_cnt_r + 6'd1;
        end
      end
    end else begin
      zero_cnt_r <= 6'd0;
    end
  end

  // Frame shift register and bit counter; the start bit is frame bit 31.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r   <= 31'd0;
      bit_cnt_r <= 5'd0;
    end else if (state_r == ST_HUNT) begin
      if (hunt_start_s) begin
        shift_r   <= 31'd1;
        bit_cnt_r <= 5'd1;
      end
    end else if (bit_vld_r) begin
      shift_r   <= word_s[30:0];
      bit_cnt_r <= bit_cnt_r + 5'd1;
    end
  end

  // LED frame counter: cleared on a new start frame, held while hunting.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_cnt <= 11'd0;
    end else if (hunt_start_s) begin
      led_cnt <= 11'd0;
    end else if (led_inc_s) begin
      led_cnt <= led_cnt_inc_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr         <= 1'b0;
      wr_data    <= 24'd0;
      wr_bright  <= 5'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr         <= wr_nxt_s;
      frame_done <= done_nxt_s;
      err        <= err_nxt_s;
      busy       <= (state_nxt_s != ST_HUNT);
      if (wr_nxt_s) begin
        wr_data   <= word_s[23:0];
        wr_bright <= word_s[28:24];
      end
      if (drop_s) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
